// File: rtl/exe_hazard_ctrl.sv
// exe_hazard_ctrl: EX-stage hazard controller for a 5-stage pipeline.
// Keeps a shadow copy of the EX, MEM and WB stage control fields. From these it:
//   - chooses the forwarding source for the two ALU operands and the store data;
//   - detects load-use hazards against the instruction in ID;
//   - sequences multi-cycle EX operations.
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   id_*              control fields of the instruction leaving ID
//   ALU_src1/2        operand mux select: 0 ID/EX value, 1 EX/MEM result, 2 WB result
//   Store_Value_sel   store-data mux select, same encoding as the ALU selects
//   stall             freeze PC and IF/ID
//   bubble            load a NOP into ID/EX instead of the ID instruction
//   exe_hold          hold ID/EX; EX/MEM loads a NOP
//   mc_start/mc_done  one-cycle pulses to the multi-cycle unit
module exe_hazard_ctrl #(
    parameter int unsigned MC_CYCLES = 4  // total EX occupancy of a multi-cycle op, 2..15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [4:0] id_src1,
    input  logic [4:0] id_src2,
    input  logic       id_src2_used,
    input  logic [4:0] id_dest,
    input  logic       id_wb_en,
    input  logic       id_mem_read,
    input  logic       id_mem_write,
    input  logic       id_multi,
    output logic [1:0] ALU_src1,
    output logic [1:0] ALU_src2,
    output logic [1:0] Store_Value_sel,
    output logic       stall,
    output logic       bubble,
    output logic       exe_hold,
    output logic       mc_start,
    output logic       mc_done
);

    // The first EX cycle is spent in idle, the last one on the cnt == 0 cycle.
    localparam logic [3:0] CntLoad = 4'(MC_CYCLES - 2);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic       ex_valid_q, ex_src2_used_q, ex_wb_en_q, ex_mem_read_q, ex_mem_write_q;
    logic       ex_multi_q;
    logic [4:0] ex_src1_q, ex_src2_q, ex_dest_q;
    logic       ex_valid_d, ex_src2_used_d, ex_wb_en_d, ex_mem_read_d, ex_mem_write_d;
    logic       ex_multi_d;
    logic [4:0] ex_src1_d, ex_src2_d, ex_dest_d;
    logic [4:0] mem_dest_q, mem_dest_d, wb_dest_q, wb_dest_d;
    logic       mem_wb_en_q, mem_wb_en_d, wb_wb_en_q, wb_wb_en_d;

    logic       load_use;
    logic       take_id;

    // Forwarding select for one source register; the younger MEM result wins over WB.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic       m_en, input logic [4:0] m_dest,
                                           input logic       w_en, input logic [4:0] w_dest);
        logic [1:0] sel;
        sel = 2'd0;
        if (src != 5'd0) begin
            if (m_en && (m_dest == src)) begin
                sel = 2'd1;
            end else if (w_en && (w_dest == src)) begin
                sel = 2'd2;
            end
        end
        return sel;
    endfunction

    // Operand selects: an immediate-operand store uses src2 only as store data.
    always_comb begin
        ALU_src1        = 2'd0;
        ALU_src2        = 2'd0;
        Store_Value_sel = 2'd0;
        if (ex_valid_q) begin
            ALU_src1 = fwd_sel(ex_src1_q, mem_wb_en_q, mem_dest_q, wb_wb_en_q, wb_dest_q);
            if (ex_mem_write_q) begin
                Store_Value_sel = fwd_sel(ex_src2_q, mem_wb_en_q, mem_dest_q,
                                          wb_wb_en_q, wb_dest_q);
            end else if (ex_src2_used_q) begin
                ALU_src2 = fwd_sel(ex_src2_q, mem_wb_en_q, mem_dest_q, wb_wb_en_q, wb_dest_q);
            end
        end
    end

    assign load_use = id_valid && ex_valid_q && ex_mem_read_q && ex_wb_en_q &&
                      (ex_dest_q != 5'd0) &&
                      ((ex_dest_q == id_src1) || (id_src2_used && (ex_dest_q == id_src2)));

    // Hold dominates; the load-use check is simply re-evaluated once the hold drops.
    assign stall  = exe_hold || load_use;
    assign bubble = load_use && !exe_hold;

    // Multi-cycle sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        exe_hold = 1'b0;
        mc_start = 1'b0;
        mc_done  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ex_valid_q && ex_multi_q) begin
                    mc_start = 1'b1;
                    exe_hold = 1'b1;
                    cnt_d    = CntLoad;
                    state_d  = StBusy;
                end
            end
            StBusy: begin
                if (cnt_q != 4'd0) begin
                    exe_hold = 1'b1;
                    cnt_d    = cnt_q - 4'd1;
                end else begin
                    mc_done = 1'b1;
                    state_d = StIdle;
                end
            end
        endcase
    end

    // Shadow pipeline advance.
    assign take_id = id_valid && !bubble;

    always_comb begin
        ex_valid_d     = ex_valid_q;
        ex_src1_d      = ex_src1_q;
        ex_src2_d      = ex_src2_q;
        ex_src2_used_d = ex_src2_used_q;
        ex_dest_d      = ex_dest_q;
        ex_wb_en_d     = ex_wb_en_q;
        ex_mem_read_d  = ex_mem_read_q;
        ex_mem_write_d = ex_mem_write_q;
        ex_multi_d     = ex_multi_q;
        mem_dest_d     = 5'd0;
        mem_wb_en_d    = 1'b0;
        wb_dest_d      = mem_dest_q;
        wb_wb_en_d     = mem_wb_en_q;
        if (!exe_hold) begin
            mem_dest_d     = ex_dest_q;
            mem_wb_en_d    = ex_wb_en_q;
            ex_valid_d     = take_id;
            ex_src1_d      = take_id ? id_src1 : 5'd0;
            ex_src2_d      = take_id ? id_src2 : 5'd0;
            ex_src2_used_d = take_id && id_src2_used;
            ex_dest_d      = take_id ? id_dest : 5'd0;
            ex_wb_en_d     = take_id && id_wb_en;
            ex_mem_read_d  = take_id && id_mem_read;
            ex_mem_write_d = take_id && id_mem_write;
            ex_multi_d     = take_id && id_multi;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            cnt_q          <= 4'd0;
            ex_valid_q     <= 1'b0;
            ex_src1_q      <= 5'd0;
            ex_src2_q      <= 5'd0;
            ex_src2_used_q <= 1'b0;
            ex_dest_q      <= 5'd0;
            ex_wb_en_q     <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            ex_mem_write_q <= 1'b0;
            ex_multi_q     <= 1'b0;
            mem_dest_q     <= 5'd0;
            mem_wb_en_q    <= 1'b0;
            wb_dest_q      <= 5'd0;
            wb_wb_en_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            ex_valid_q     <= ex_valid_d;
            ex_src1_q      <= ex_src1_d;
            ex_src2_q      <= ex_src2_d;
            ex_src2_used_q <= ex_src2_used_d;
            ex_dest_q      <= ex_dest_d;
            ex_wb_en_q     <= ex_wb_en_d;
            ex_mem_read_q  <= ex_mem_read_d;
            ex_mem_write_q <= ex_mem_write_d;
            ex_multi_q     <= ex_multi_d;
            mem_dest_q     <= mem_dest_d;
            mem_wb_en_q    <= mem_wb_en_d;
            wb_dest_q      <= wb_dest_d;
            wb_wb_en_q     <= wb_wb_en_d;
        end
    end

endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// Bench for exe_hazard_ctrl: directed instruction sequences with hand-computed checks,
// plus a per-cycle comparison against an instruction-level pipeline model.
module tb_exe_hazard_ctrl;

    localparam int MC = 4;

    typedef struct packed {
        logic       valid;
        logic [4:0] src1;
        logic [4:0] src2;
        logic       src2_used;
        logic [4:0] dest;
        logic       wb_en;
        logic       mem_read;
        logic       mem_write;
        logic       multi;
    } instr_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    instr_t     id = '0;
    logic [1:0] ALU_src1, ALU_src2, Store_Value_sel;
    logic       stall, bubble, exe_hold, mc_start, mc_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exe_hazard_ctrl #(.MC_CYCLES(MC)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id.valid),
        .id_src1        (id.src1),
        .id_src2        (id.src2),
        .id_src2_used   (id.src2_used),
        .id_dest        (id.dest),
        .id_wb_en       (id.wb_en),
        .id_mem_read    (id.mem_read),
        .id_mem_write   (id.mem_write),
        .id_multi       (id.multi),
        .ALU_src1       (ALU_src1),
        .ALU_src2       (ALU_src2),
        .Store_Value_sel(Store_Value_sel),
        .stall          (stall),
        .bubble         (bubble),
        .exe_hold       (exe_hold),
        .mc_start       (mc_start),
        .mc_done        (mc_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction-level model ----------------
    // m_ex is the instruction in EX, m_mem/m_wb the two older ones; m_age counts cycles
    // the current EX instruction has already spent in EX.
    instr_t m_ex = '0;
    instr_t m_mem = '0;
    instr_t m_wb = '0;
    int     m_age = 0;

    function automatic logic m_hold();
        return m_ex.valid && m_ex.multi && (m_age < MC - 1);
    endfunction

    function automatic logic m_lu();
        return id.valid && m_ex.valid && m_ex.mem_read && m_ex.wb_en && (m_ex.dest != 0) &&
               ((m_ex.dest == id.src1) || (id.src2_used && (m_ex.dest == id.src2)));
    endfunction

    // Youngest older instruction writing r wins; 1 = MEM, 2 = WB.
    function automatic logic [1:0] m_fwd(input logic [4:0] r);
        instr_t older [2];
        logic [1:0] res;
        logic found;
        older[0] = m_mem;
        older[1] = m_wb;
        res = 2'd0;
        found = 1'b0;
        for (int s = 0; s < 2; s++) begin
            if (!found && r != 0 && older[s].wb_en && older[s].dest == r) begin
                res = 2'(s + 1);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ex  <= '0;
            m_mem <= '0;
            m_wb  <= '0;
            m_age <= 0;
        end else begin
            m_wb <= m_mem;
            if (m_hold()) begin
                m_mem <= '0;
                m_age <= m_age + 1;
            end else begin
                m_mem <= m_ex;
                m_ex  <= (id.valid && !m_lu()) ? id : '0;
                m_age <= 0;
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        logic e_hold, e_lu;
        e_hold = m_hold();
        e_lu   = m_lu();
        check("model ALU_src1", 32'(ALU_src1), m_ex.valid ? 32'(m_fwd(m_ex.src1)) : 0);
        check("model ALU_src2", 32'(ALU_src2),
              (m_ex.valid && m_ex.src2_used && !m_ex.mem_write) ? 32'(m_fwd(m_ex.src2)) : 0);
        check("model Store_Value_sel", 32'(Store_Value_sel),
              (m_ex.valid && m_ex.mem_write) ? 32'(m_fwd(m_ex.src2)) : 0);
        check("model exe_hold", 32'(exe_hold), 32'(e_hold));
        check("model stall", 32'(stall), 32'(e_hold || e_lu));
        check("model bubble", 32'(bubble), 32'(e_lu && !e_hold));
        check("model mc_start", 32'(mc_start), 32'(m_ex.valid && m_ex.multi && m_age == 0));
        check("model mc_done", 32'(mc_done), 32'(m_ex.valid && m_ex.multi && m_age == MC - 1));
    end

    // ---------------- directed stimulus ----------------
    function automatic instr_t mk(input int s1, input int s2, input bit s2u, input int d,
                                  input bit wb, input bit mr, input bit mw, input bit mu);
        instr_t i;
        i.valid     = 1'b1;
        i.src1      = 5'(s1);
        i.src2      = 5'(s2);
        i.src2_used = s2u;
        i.dest      = 5'(d);
        i.wb_en     = wb;
        i.mem_read  = mr;
        i.mem_write = mw;
        i.multi     = mu;
        return i;
    endfunction

    // One cycle with instruction i presented in ID; returns just after the falling edge.
    task automatic cyc(input instr_t i);
        @(posedge clk);
        #1;
        id = i;
        @(negedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, " ALU_src1"}, 32'(ALU_src1), 0);
        check({tag, " ALU_src2"}, 32'(ALU_src2), 0);
        check({tag, " Store_Value_sel"}, 32'(Store_Value_sel), 0);
        check({tag, " stall"}, 32'(stall), 0);
        check({tag, " bubble"}, 32'(bubble), 0);
        check({tag, " exe_hold"}, 32'(exe_hold), 0);
        check({tag, " mc_start"}, 32'(mc_start), 0);
        check({tag, " mc_done"}, 32'(mc_done), 0);
    endtask

    initial begin
        instr_t nop, add3, add4_r3, add5_r3, add0, add6_r0, lw5, add6_r5, add7, sw7;
        instr_t mul8, add9_r8, mul10;
        nop     = '0;
        add3    = mk(1, 2, 1, 3, 1, 0, 0, 0);
        add4_r3 = mk(3, 1, 1, 4, 1, 0, 0, 0);
        add5_r3 = mk(3, 0, 1, 5, 1, 0, 0, 0);
        add0    = mk(1, 1, 1, 0, 1, 0, 0, 0);
        add6_r0 = mk(0, 0, 1, 6, 1, 0, 0, 0);
        lw5     = mk(1, 0, 0, 5, 1, 1, 0, 0);
        add6_r5 = mk(5, 2, 1, 6, 1, 0, 0, 0);
        add7    = mk(1, 2, 1, 7, 1, 0, 0, 0);
        sw7     = mk(1, 7, 1, 0, 0, 0, 1, 0);
        mul8    = mk(1, 2, 1, 8, 1, 0, 0, 1);
        add9_r8 = mk(8, 1, 1, 9, 1, 0, 0, 0);
        mul10   = mk(3, 4, 1, 10, 1, 0, 0, 1);

        // Reset, then the first cycle after release.
        @(negedge clk);
        #1;
        check_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        check_zero("post-reset");

        // Back-to-back dependency, then with one NOP between.
        cyc(add3);                                            // c1
        cyc(add4_r3);                                         // c2
        cyc(nop);                                             // c3
        check("b2b ALU_src1", 32'(ALU_src1), 1);
        cyc(add3);                                            // c4
        cyc(nop);                                             // c5
        cyc(add4_r3);                                         // c6
        cyc(nop);                                             // c7
        check("nop-gap ALU_src1", 32'(ALU_src1), 2);

        // r3 in both MEM and WB; r0 never forwarded.
        cyc(add3);                                            // c8
        cyc(add3);                                            // c9
        cyc(add5_r3);                                         // c10
        cyc(add0);                                            // c11
        check("mem-over-wb ALU_src1", 32'(ALU_src1), 1);
        cyc(add6_r0);                                         // c12
        cyc(nop);                                             // c13
        check("r0 ALU_src1", 32'(ALU_src1), 0);
        check("r0 ALU_src2", 32'(ALU_src2), 0);

        // Load-use: one stall cycle, then WB forwarding.
        cyc(lw5);                                             // c14
        cyc(add6_r5);                                         // c15
        check("load-use stall", 32'(stall), 1);
        check("load-use bubble", 32'(bubble), 1);
        cyc(add6_r5);                                         // c16 (ID frozen)
        check("after load-use stall", 32'(stall), 0);
        check("after load-use bubble", 32'(bubble), 0);
        cyc(nop);                                             // c17
        check("load-use ALU_src1", 32'(ALU_src1), 2);
        check("load-use fwd stall", 32'(stall), 0);

        // Store data forwarded from the preceding instruction.
        cyc(add7);                                            // c18
        cyc(sw7);                                             // c19
        cyc(nop);                                             // c20
        check("store Store_Value_sel", 32'(Store_Value_sel), 1);
        check("store ALU_src2", 32'(ALU_src2), 0);

        // Multi-cycle op, then a dependent instruction.
        cyc(mul8);                                            // c21
        cyc(add9_r8);                                         // c22
        check("mc cycle1 mc_start", 32'(mc_start), 1);
        check("mc cycle1 exe_hold", 32'(exe_hold), 1);
        check("mc cycle1 bubble", 32'(bubble), 0);
        cyc(add9_r8);                                         // c23
        check("mc cycle2 exe_hold", 32'(exe_hold), 1);
        check("mc cycle2 mc_start", 32'(mc_start), 0);
        cyc(add9_r8);                                         // c24
        check("mc cycle3 exe_hold", 32'(exe_hold), 1);
        cyc(add9_r8);                                         // c25
        check("mc cycle4 mc_done", 32'(mc_done), 1);
        check("mc cycle4 exe_hold", 32'(exe_hold), 0);
        cyc(nop);                                             // c26
        check("mc cycle5 ALU_src1", 32'(ALU_src1), 1);
        check("mc cycle5 mc_done", 32'(mc_done), 0);

        // Back-to-back multi-cycle ops: no gap cycle.
        cyc(mul10);                                           // c27
        cyc(mul8);                                            // c28
        cyc(mul8);                                            // c29
        cyc(mul8);                                            // c30
        cyc(mul8);                                            // c31
        check("b2b mc mc_done", 32'(mc_done), 1);
        cyc(nop);                                             // c32
        check("b2b mc mc_start", 32'(mc_start), 1);
        check("b2b mc mc_done low", 32'(mc_done), 0);
        repeat (4) cyc(nop);                                  // c33-c36

        // Reset during BUSY with cnt = 1.
        cyc(mul10);                                           // c37
        cyc(nop);                                             // c38 start
        cyc(nop);                                             // c39
        cyc(nop);                                             // c40
        check("pre-reset exe_hold", 32'(exe_hold), 1);
        rst = 1'b1;
        #1;
        check_zero("async reset");
        cyc(nop);                                             // c41
        check_zero("reset held");
        rst = 1'b0;
        cyc(nop);                                             // c42
        check_zero("after mid-op reset");
        cyc(mul8);                                            // c43
        cyc(nop);                                             // c44
        check("idle after reset mc_start", 32'(mc_start), 1);
        repeat (5) cyc(nop);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
